// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op encodings and FSM states for the multiply/divide unit
package muldiv_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand magnitudes, radix-2 shift-add / restoring-divide step and sign fix
module muldiv_datapath import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] acc, prod;
    logic               is_div, neg_q, neg_r, sa, sb, ge;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, trial;

    // operand magnitudes/signs at launch and one iteration of the selected algorithm
    always_comb begin
        sa     = !op[0] && opA[WIDTH-1];
        sb     = !op[0] && opB[WIDTH-1];
        mag_a  = sa ? -opA : opA;
        mag_b  = sb ? -opB : opB;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
        trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, a};
        ge     = !trial[WIDTH];
        prod   = neg_q ? -acc : acc;
        res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
    end

    // working registers: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a      <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load) begin
            a      <= op[1] ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
        end else if (step) begin
            acc <= is_div ? (ge ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0})
                          : {sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_e           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             go, dz, load;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (state == RUN),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // launch decode and next-state: divide by zero skips straight to DONE
    always_comb begin
        go      = state == IDLE && start;
        dz      = go && op[1] && opB == '0;
        load    = go && !dz;
        state_n = state;
        case (state)
            IDLE:    state_n = dz ? DONE : go ? RUN : IDLE;
            RUN:     state_n = cnt == CW'(WIDTH-1) ? FIX : RUN;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // state, iteration counter, handshake flags and HI/LO (start beats mt_*; mt_* only in IDLE)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_n;
            cnt   <= load ? '0 : state == RUN ? cnt + 1'b1 : cnt;
            busy  <= state_n == RUN || state_n == FIX;
            done  <= state_n == DONE;
            if (go) div_zero <= dz;
            hi <= state == FIX ? res_hi : (state == IDLE && !start && mt_hi) ? opA : hi;
            lo <= state == FIX ? res_lo : (state == IDLE && !start && mt_lo) ? opA : lo;
        end
    end
endmodule
